ps2_rx_fifo: RTL and testbench
==============================

# ps2_rx_fifo

Parametrised PS/2 device-to-host receiver. It replaces the single-byte `ps2_rx` with the following additions:
- configurable glitch filter;
- full 11-bit frame checking (start, odd parity, stop);
- optional inter-bit timeout;
- a DEPTH-entry output FIFO with valid/ready handshake.

It sits between the keyboard/mouse pins (already synchronised only by this block) and the scan-code decoder.

## Interface
- FILTER_STEPS, 2: consecutive equal ps2c samples needed to change the filtered clock level; legal values are 2 to 16.
- DEPTH, 4: FIFO entries; must be a power of two and ≥ 2.
- TIMEOUT_CYCLES, 10000: clk cycles with no filtered ps2c edge before a partial frame is aborted.

- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- ps2c  in  1  raw PS/2 clock pin
- ps2d  in  1  raw PS/2 data pin
- en  in  1  receive enable
- m_data  out  8  FIFO head byte
- m_valid  out  1  FIFO non-empty
- m_ready  in  1  consumer accepts head
- level  out  $clog2(DEPTH+1)  FIFO occupancy
- busy  out  1  frame in progress (state ≠ IDLE)
- err_parity  out  1  one-cycle pulse: parity failure
- err_frame  out  1  one-cycle pulse: stop bit was 0
- err_timeout  out  1  one-cycle pulse: timeout abort
- overflow  out  1  one-cycle pulse: good byte dropped because the FIFO was full

## Operation
**Front end**
- ps2c and ps2d each pass through a 2-FF synchroniser.
- ps2c then feeds a FILTER_STEPS-deep shift register. The filtered level goes to 0 when all samples are 0, goes to 1 when all are 1, and holds otherwise.
- `fall` is a one-cycle pulse on a filtered 1→0 transition. The synchronised ps2d is sampled on `fall`.

**FSM states:** IDLE, DATA, PARITY, STOP.
- IDLE: on `fall` with ps2d=0 → DATA, and clear the bit counter and shift register. A `fall` with ps2d=1 is ignored.
- DATA: on each `fall`, shift the sampled bit in LSB-first and increment the 3-bit counter. On the 8th bit → PARITY.
- PARITY: on `fall`, latch the parity bit → STOP.
- STOP: on `fall` → IDLE, then evaluate the frame:
  - Stop bit 0: pulse err_frame, no push. Parity is not reported for this frame.
  - Otherwise, if XOR of the 8 data bits and the parity bit is 0: pulse err_parity, no push.
  - Otherwise: push the byte.

**Enable**
- en=0 forces IDLE immediately and discards any partial frame, with no error pulse.
- The FIFO continues to drain while en=0.

**FIFO**
- Pop when m_valid && m_ready.
- A push while full is accepted only if a pop occurs in the same cycle. Otherwise the byte is dropped and overflow pulses.
- The read and write pointers are $clog2(DEPTH) bits wide and wrap naturally. level is updated with a single ±1/0 arithmetic step.

**Reset values:** m_data=0, m_valid=0, level=0, busy=0, all error/overflow pulses 0, FSM=IDLE, filtered clock=1, synchronisers=1.

## Timing
- `fall` asserts exactly FILTER_STEPS+3 clk cycles after the first clk edge that samples ps2c low.
- Glitches shorter than FILTER_STEPS cycles produce no `fall`.
- The push occurs on the cycle after the STOP `fall`. m_valid and level update on the clk edge that performs the push.
- m_data is the combinational FIFO head (first-word fall-through), with 0 pop latency.
- Error and overflow pulses align with the push cycle.
- Minimum supported PS/2 half-period is FILTER_STEPS+2 clk cycles.

## Configuration
`PS2_RX_TIMEOUT_EN` enables the timeout.

**Defined:**
- A counter of $clog2(TIMEOUT_CYCLES+1) bits clears on each `fall` and in IDLE, and increments otherwise.
- When it reaches TIMEOUT_CYCLES while busy, the FSM returns to IDLE, the partial byte is discarded, and err_timeout pulses.

**Undefined:**
- No counter is built and err_timeout is tied to 0.
- TIMEOUT_CYCLES is unused.
- A stalled frame remains in progress until the next `fall` or until en=0.

## Structure
- ps2_pkg:
  - state enum `ps2_state_t` {IDLE, DATA, PARITY, STOP};
  - `PS2_DATA_BITS=8`;
  - `PS2_FRAME_BITS=11`;
  - function `ps2_odd_ok(data, parity)`.
- Sub-module ps2_filter: synchronisers, glitch filter, `fall` pulse, synchronised data output.
- The FSM and FIFO are inline in ps2_rx_fifo.

## Test plan
- Send frame 0x3C with parity=1, stop=1, PS/2 half-period 6 → m_valid rises, m_data=0x3C, level=1, no error pulses.
- Send 10'h23C, 10'h25A, 10'h2A5, 10'h2C3, 10'h269, 10'h296 (even-weight data, parity 0) → six err_parity pulses, level stays 0.
- Set DEPTH=4 and m_ready=0, then send 0x11, 0x22, 0x33, 0x44, 0x55 (valid parity) → level=4, one overflow pulse on the 5th byte. After draining, the FIFO yields 0x11..0x44 in order.
- Send frame 0x5A with stop=0 → err_frame pulse, no push. Inject a 1-cycle low glitch on ps2c in IDLE → no `fall`, busy stays 0.
- With `PS2_RX_TIMEOUT_EN` and TIMEOUT_CYCLES=200: send a start bit plus 3 data bits, then hold ps2c high → err_timeout exactly 200 cycles after the last `fall`, busy=0. The next full frame 0x3C is received correctly.
- Drop en mid-frame → immediate IDLE, no pulses. Assert rst mid-frame with level=2 → all outputs at their reset values asynchronously.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types and frame helpers.
// Used by ps2_filter and ps2_rx_fifo.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_BITS = 11;

  // PS/2 uses odd parity over data plus parity bit
  function automatic logic ps2_odd_ok(
    input logic [PS2_DATA_BITS-1:0] data,
    input logic                     parity
  );
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// PS/2 pin front end: 2-FF synchronisers, clock glitch filter
// and a one-cycle pulse on each filtered falling clock edge.
module ps2_filter #(
  parameter int FILTER_STEPS = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2c,
  input  logic ps2d,
  output logic fall,
  output logic data
);

  logic [1:0]              c_sync;
  logic [1:0]              d_sync;
  logic [FILTER_STEPS-1:0] hist;
  logic                    filt;
  logic                    filt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_sync <= 2'b11;
      d_sync <= 2'b11;
      hist   <= '1;
      filt   <= 1'b1;
      filt_q <= 1'b1;
      fall   <= 1'b0;
    end else begin
      c_sync <= {c_sync[0], ps2c};
      d_sync <= {d_sync[0], ps2d};
      hist   <= {hist[FILTER_STEPS-2:0], c_sync[1]};
      if (hist == '0)
        filt <= 1'b0;
      else if (hist == '1)
        filt <= 1'b1;
      filt_q <= filt;
      fall   <= filt_q & ~filt;
    end
  end

  assign data = d_sync[1];

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with frame checks and output FIFO.
// Define PS2_RX_TIMEOUT_EN to build the inter-bit timeout abort.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FILTER_STEPS   = 2,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ps2c,
  input  logic                       ps2d,
  input  logic                       en,
  output logic [7:0]                 m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       busy,
  output logic                       err_parity,
  output logic                       err_frame,
  output logic                       err_timeout,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic fall;
  logic data;

  ps2_filter #(
    .FILTER_STEPS(FILTER_STEPS)
  ) u_filter (
    .clk (clk),
    .rst (rst),
    .ps2c(ps2c),
    .ps2d(data_pin_unused_guard(ps2d)),
    .fall(fall),
    .data(data)
  );

  function automatic logic data_pin_unused_guard(input logic d);
    return d;
  endfunction

  ps2_state_t                state;
  ps2_state_t                nxt;
  logic [2:0]                cnt;
  logic [PS2_DATA_BITS-1:0]  shreg;
  logic                      par;
  logic                      push_req;
  logic                      tmo;

  assign busy = (state != IDLE);

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  logic [TW-1:0] tcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tcnt <= '0;
    else if (fall || state == IDLE)
      tcnt <= '0;
    else
      tcnt <= tcnt + 1'b1;
  end

  // A fall arriving on the expiry cycle keeps the frame alive
  assign tmo = busy && !fall && (tcnt == TW'(TIMEOUT_CYCLES));
`else
  assign tmo = 1'b0;
`endif

  assign err_timeout = tmo && en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (!en || tmo) begin
      nxt = IDLE;
    end else if (fall) begin
      unique case (state)
        IDLE:    if (!data) nxt = DATA;
        DATA:    if (cnt == 3'd7) nxt = PARITY;
        PARITY:  nxt = STOP;
        STOP:    nxt = IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      push_req   <= 1'b0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
    end else begin
      push_req   <= 1'b0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
      if (en && fall) begin
        unique case (state)
          IDLE: begin
            cnt   <= '0;
            shreg <= '0;
          end
          DATA: begin
            shreg <= {data, shreg[PS2_DATA_BITS-1:1]};
            cnt   <= cnt + 1'b1;
          end
          PARITY: par <= data;
          STOP: begin
            if (!data)
              err_frame <= 1'b1;
            else if (!ps2_odd_ok(shreg, par))
              err_parity <= 1'b1;
            else
              push_req <= 1'b1;
          end
        endcase
      end
    end
  end

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          full;
  logic          pop;
  logic          wr;

  assign full     = (level == LW'(DEPTH));
  assign m_valid  = (level != '0);
  assign pop      = m_valid && m_ready;
  assign wr       = push_req && (!full || pop);
  assign overflow = push_req && full && !pop;
  assign m_data   = m_valid ? mem[rptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (wr)
      mem[wptr] <= shreg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      unique case ({wr, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: table of frames plus FIFO,
// glitch, enable, reset and (optionally) timeout sequences.
module tb_ps2_rx_fifo;

  localparam int FS    = 2;
  localparam int DEPTH = 4;
  localparam int TMO   = 200;
  localparam int HALF  = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2c;
  logic       ps2d;
  logic       en;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic [2:0] level;
  logic       busy;
  logic       err_parity;
  logic       err_frame;
  logic       err_timeout;
  logic       overflow;

  ps2_rx_fifo #(
    .FILTER_STEPS  (FS),
    .DEPTH         (DEPTH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2c       (ps2c),
    .ps2d       (ps2d),
    .en         (en),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .level      (level),
    .busy       (busy),
    .err_parity (err_parity),
    .err_frame  (err_frame),
    .err_timeout(err_timeout),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;
  int n_perr = 0;
  int n_ferr = 0;
  int n_tmo = 0;
  int n_ovf = 0;
  int n_busy = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (err_parity)  n_perr++;
      if (err_frame)   n_ferr++;
      if (err_timeout) n_tmo++;
      if (overflow)    n_ovf++;
      if (busy)        n_busy++;
    end
  end

  typedef struct {
    logic [7:0] d;
    bit         p;
    bit         s;
    bit         push;
    bit         perr;
    bit         ferr;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input bit b);
    ps2d = b;
    tick(HALF);
    ps2c = 1'b0;
    tick(HALF);
    ps2c = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit p, input bit s);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
    ps2d = 1'b1;
    tick(12);
  endtask

  task automatic pop_one;
    m_ready = 1'b1;
    tick(1);
    m_ready = 1'b0;
  endtask

  int p0, f0, o0, t0, b0;
  logic [7:0] exp_b [4];

  initial begin
    rst = 1'b1; ps2c = 1'b1; ps2d = 1'b1; en = 1'b1; m_ready = 1'b0;
    tick(5);
    check("rst_m_valid", m_valid, 0);
    check("rst_level",   level,   0);
    check("rst_busy",    busy,    0);
    check("rst_m_data",  m_data,  0);
    rst = 1'b0;
    tick(5);

    tbl[0]  = '{8'h3C, 1, 1, 1, 0, 0};
    tbl[1]  = '{8'h3C, 0, 1, 0, 1, 0};
    tbl[2]  = '{8'h5A, 0, 1, 0, 1, 0};
    tbl[3]  = '{8'hA5, 0, 1, 0, 1, 0};
    tbl[4]  = '{8'hC3, 0, 1, 0, 1, 0};
    tbl[5]  = '{8'h69, 0, 1, 0, 1, 0};
    tbl[6]  = '{8'h96, 0, 1, 0, 1, 0};
    tbl[7]  = '{8'h5A, 1, 0, 0, 0, 1};
    tbl[8]  = '{8'h5A, 0, 0, 0, 0, 1};
    tbl[9]  = '{8'h01, 0, 1, 1, 0, 0};
    tbl[10] = '{8'hFF, 1, 1, 1, 0, 0};
    tbl[11] = '{8'h80, 0, 1, 1, 0, 0};

    for (int k = 0; k < 12; k++) begin
      p0 = n_perr; f0 = n_ferr;
      send_frame(tbl[k].d, tbl[k].p, tbl[k].s);
      check($sformatf("v%0d_perr", k), n_perr - p0, tbl[k].perr);
      check($sformatf("v%0d_ferr", k), n_ferr - f0, tbl[k].ferr);
      check($sformatf("v%0d_level", k), level, tbl[k].push);
      check($sformatf("v%0d_valid", k), m_valid, tbl[k].push);
      if (tbl[k].push) begin
        check($sformatf("v%0d_data", k), m_data, tbl[k].d);
        pop_one();
        check($sformatf("v%0d_level_pop", k), level, 0);
      end
    end

    // overflow: fill DEPTH entries then one more
    exp_b[0] = 8'h11; exp_b[1] = 8'h22;
    exp_b[2] = 8'h33; exp_b[3] = 8'h44;
    o0 = n_ovf;
    for (int k = 0; k < 4; k++) send_frame(exp_b[k], 1, 1);
    check("fill_level", level, 4);
    check("fill_ovf", n_ovf - o0, 0);
    send_frame(8'h55, 1, 1);
    check("ovf_level", level, 4);
    check("ovf_pulse", n_ovf - o0, 1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain%0d", k), m_data, exp_b[k]);
      pop_one();
    end
    check("drain_level", level, 0);
    check("drain_valid", m_valid, 0);

    // short glitch in idle
    b0 = n_busy;
    ps2c = 1'b0;
    tick(1);
    ps2c = 1'b1;
    tick(20);
    check("glitch_busy", n_busy - b0, 0);
    check("glitch_level", level, 0);

    // drop enable mid-frame
    p0 = n_perr; f0 = n_ferr; t0 = n_tmo;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    tick(2);
    check("en_busy_before", busy, 1);
    en = 1'b0;
    tick(1);
    check("en_busy_after", busy, 0);
    tick(5);
    check("en_pulses", (n_perr - p0) + (n_ferr - f0) + (n_tmo - t0), 0);
    check("en_level", level, 0);
    en = 1'b1;
    tick(5);
    send_frame(8'hA5, 1, 1);
    check("en_recover_level", level, 1);
    check("en_recover_data", m_data, 8'hA5);
    pop_one();

`ifdef PS2_RX_TIMEOUT_EN
    t0 = n_tmo;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    for (int c = 0; c < 400 && n_tmo == t0; c++) tick(1);
    check("tmo_pulse", n_tmo - t0, 1);
    tick(1);
    check("tmo_busy", busy, 0);
    send_frame(8'h3C, 1, 1);
    check("tmo_next_data", m_data, 8'h3C);
    check("tmo_next_level", level, 1);
    pop_one();
`endif

    // async reset mid-frame with two bytes queued
    send_frame(8'h11, 1, 1);
    send_frame(8'h22, 1, 1);
    check("pre_rst_level", level, 2);
    send_bit(1'b0);
    send_bit(1'b1);
    tick(2);
    check("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_level", level, 0);
    check("arst_valid", m_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_data", m_data, 0);
    check("arst_pulses",
          {err_parity, err_frame, err_timeout, overflow}, 0);
    ps2c = 1'b1; ps2d = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(5);
    send_frame(8'h3C, 1, 1);
    check("post_rst_data", m_data, 8'h3C);
    check("post_rst_level", level, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
